// File: rtl/inst_rom_loader.sv
// Boot-loaded instruction ROM: assembles a big-endian byte stream into 32-bit
// words, holds the core in reset until the image is complete, then serves
// combinational (0-cycle) fetches gated by ce, RUN state and the loaded count.
// Ports: clk/rst (async active-high); ld_valid_i/ld_byte_i/ld_last_i/ld_ready_o
// load stream; rom_ce_i/rom_addr_i/rom_data_o fetch; cpu_rst_o, ld_done_o,
// ld_err_o (sticky), word_cnt_o status.
module inst_rom_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid_i,
  input  logic [7:0]        ld_byte_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  output logic              cpu_rst_o,
  output logic              ld_done_o,
  output logic              ld_err_o,
  output logic [ADDR_W:0]   word_cnt_o
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  localparam int DEPTH = 1 << ADDR_W;

  state_t            state_q, state_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       asm_q, asm_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic              ld_ready_q, ld_ready_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              ld_done_q, ld_done_d;
  logic              ld_err_q, ld_err_d;

  logic [31:0]       mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;

  logic              accept;
  logic              last_slot;
  logic [ADDR_W-1:0] fetch_idx;
  logic              fetch_hit;
  logic              unused_addr_bits;

  // Registered ready doubles as "state is LOAD", so accept has no comb depth.
  assign accept    = ld_valid_i & ld_ready_q;
  assign last_slot = (word_cnt_q[ADDR_W-1:0] == {ADDR_W{1'b1}});

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    word_cnt_d = word_cnt_q;
    mem_we     = 1'b0;
    mem_waddr  = word_cnt_q[ADDR_W-1:0];
    mem_wdata  = {asm_q, ld_byte_i};

    if (state_q == ST_LOAD && accept) begin
      case (byte_idx_q)
        2'd0: asm_d[23:16] = ld_byte_i;
        2'd1: asm_d[15:8]  = ld_byte_i;
        2'd2: asm_d[7:0]   = ld_byte_i;
        default: asm_d     = 24'h0;
      endcase

      if (byte_idx_q == 2'd3) begin
        mem_we     = 1'b1;
        word_cnt_d = word_cnt_q + (ADDR_W+1)'(1);
        byte_idx_d = 2'd0;
        if (ld_last_i) begin
          state_d = ST_RUN;
        end else if (last_slot) begin
          // Image longer than the array: keep the final word, flag overflow.
          state_d = ST_ERR;
        end
      end else begin
        byte_idx_d = byte_idx_q + 2'd1;
        // Last marker mid-word: the partial word is never written.
        if (ld_last_i) begin
          state_d = ST_ERR;
        end
      end
    end

    ld_ready_d = (state_d == ST_LOAD);
    cpu_rst_d  = (state_d != ST_RUN);
    ld_done_d  = (state_d == ST_RUN);
    ld_err_d   = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      byte_idx_q <= 2'd0;
      asm_q      <= 24'h0;
      word_cnt_q <= '0;
      ld_ready_q <= 1'b1;
      cpu_rst_q  <= 1'b1;
      ld_done_q  <= 1'b0;
      ld_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      word_cnt_q <= word_cnt_d;
      ld_ready_q <= ld_ready_d;
      cpu_rst_q  <= cpu_rst_d;
      ld_done_q  <= ld_done_d;
      ld_err_q   <= ld_err_d;
    end
  end

  // Array is deliberately not reset; stale words are hidden by the count compare.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Byte offset and upper address bits are dropped, so the image aliases.
  assign fetch_idx = rom_addr_i[ADDR_W+1:2];
  assign fetch_hit = rom_ce_i && (state_q == ST_RUN) && ({1'b0, fetch_idx} < word_cnt_q);
  assign rom_data_o = fetch_hit ? mem[fetch_idx] : 32'h0;

  assign unused_addr_bits = ^{rom_addr_i[31:ADDR_W+2], rom_addr_i[1:0]};

  assign ld_ready_o = ld_ready_q;
  assign cpu_rst_o  = cpu_rst_q;
  assign ld_done_o  = ld_done_q;
  assign ld_err_o   = ld_err_q;
  assign word_cnt_o = word_cnt_q;

endmodule

// File: tb/tb_inst_rom_loader.sv
module tb_inst_rom_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_byte = 8'h0;
  logic        ld_last = 1'b0;
  logic        rom_ce = 1'b0;
  logic [31:0] rom_addr = 32'h0;

  // ADDR_W=10 instance
  logic        ready_a, cpu_rst_a, done_a, err_a;
  logic [31:0] data_a;
  logic [10:0] cnt_a;
  // ADDR_W=2 instance for the overflow cases; shares every input
  logic        ready_b, cpu_rst_b, done_b, err_b;
  logic [31:0] data_b;
  logic [2:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_rom_loader #(.ADDR_W(10)) dut (
    .clk(clk), .rst(rst),
    .ld_valid_i(ld_valid), .ld_byte_i(ld_byte), .ld_last_i(ld_last),
    .ld_ready_o(ready_a),
    .rom_ce_i(rom_ce), .rom_addr_i(rom_addr), .rom_data_o(data_a),
    .cpu_rst_o(cpu_rst_a), .ld_done_o(done_a), .ld_err_o(err_a),
    .word_cnt_o(cnt_a)
  );

  inst_rom_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .ld_valid_i(ld_valid), .ld_byte_i(ld_byte), .ld_last_i(ld_last),
    .ld_ready_o(ready_b),
    .rom_ce_i(rom_ce), .rom_addr_i(rom_addr), .rom_data_o(data_b),
    .cpu_rst_o(cpu_rst_b), .ld_done_o(done_b), .ld_err_o(err_b),
    .word_cnt_o(cnt_b)
  );

  typedef struct {
    logic        ce;
    logic [31:0] addr;
    logic [31:0] exp;
  } fetch_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fetch(input string name, input logic ce, input logic [31:0] addr,
                       input logic [31:0] exp);
    rom_ce   = ce;
    rom_addr = addr;
    #1;
    chk(name, data_a, exp);
  endtask

  task automatic send(input logic [7:0] b, input logic last, input int gaps);
    repeat (gaps) @(negedge clk);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_last  = last;
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0] img [8];
  fetch_vec_t fv [7];

  initial begin
    img = '{8'h34, 8'h01, 8'h00, 8'h05, 8'h3C, 8'h02, 8'h12, 8'h34};
    fv[0] = '{1'b1, 32'h0000_0000, 32'h3401_0005};
    fv[1] = '{1'b1, 32'h0000_0004, 32'h3C02_1234};
    fv[2] = '{1'b1, 32'h0000_0008, 32'h0000_0000};
    fv[3] = '{1'b0, 32'h0000_0000, 32'h0000_0000};
    fv[4] = '{1'b1, 32'h0000_1004, 32'h3C02_1234};
    fv[5] = '{1'b1, 32'h0000_0003, 32'h3401_0005};
    fv[6] = '{1'b1, 32'hFFFF_F000, 32'h3401_0005};

    // Reset state
    rom_ce = 1'b1;
    rom_addr = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, ready_a}, 32'd1);
    chk("rst_cpu_rst", {31'b0, cpu_rst_a}, 32'd1);
    chk("rst_done", {31'b0, done_a}, 32'd0);
    chk("rst_err", {31'b0, err_a}, 32'd0);
    chk("rst_cnt", {21'b0, cnt_a}, 32'd0);
    chk("rst_data", data_a, 32'h0);
    rst = 1'b0;

    // Basic load; check cpu_rst falls exactly on the edge taking the last byte
    for (int i = 0; i < 7; i++) send(img[i], 1'b0, 0);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_byte  = img[7];
    ld_last  = 1'b1;
    #1;
    chk("pre_last_cpu_rst", {31'b0, cpu_rst_a}, 32'd1);
    chk("pre_last_ready", {31'b0, ready_a}, 32'd1);
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("load_cpu_rst", {31'b0, cpu_rst_a}, 32'd0);
    chk("load_done", {31'b0, done_a}, 32'd1);
    chk("load_ready", {31'b0, ready_a}, 32'd0);
    chk("load_cnt", {21'b0, cnt_a}, 32'd2);

    for (int i = 0; i < 7; i++) begin
      rom_ce   = fv[i].ce;
      rom_addr = fv[i].addr;
      #1;
      chk($sformatf("fetch_vec%0d", i), data_a, fv[i].exp);
    end

    // Same image with random idle gaps, then bytes offered in RUN
    do_reset();
    for (int i = 0; i < 8; i++) send(img[i], i == 7, int'($urandom_range(0, 3)));
    chk("gap_cnt", {21'b0, cnt_a}, 32'd2);
    fetch("gap_w0", 1'b1, 32'h0, 32'h3401_0005);
    fetch("gap_w1", 1'b1, 32'h4, 32'h3C02_1234);
    for (int i = 0; i < 4; i++) send(8'hEE, i == 3, 0);
    chk("run_ignore_cnt", {21'b0, cnt_a}, 32'd2);
    fetch("run_ignore_w0", 1'b1, 32'h0, 32'h3401_0005);
    fetch("run_ignore_w2", 1'b1, 32'h8, 32'h0);

    // Early last on byte 6
    do_reset();
    for (int i = 0; i < 6; i++) send(img[i], i == 5, 0);
    repeat (2) @(negedge clk);
    chk("early_err", {31'b0, err_a}, 32'd1);
    chk("early_cpu_rst", {31'b0, cpu_rst_a}, 32'd1);
    chk("early_done", {31'b0, done_a}, 32'd0);
    chk("early_ready", {31'b0, ready_a}, 32'd0);
    chk("early_cnt", {21'b0, cnt_a}, 32'd1);
    fetch("early_f0", 1'b1, 32'h0, 32'h0);
    fetch("early_f4", 1'b1, 32'h4, 32'h0);

    // Exact fill of the 4-word instance
    do_reset();
    for (int i = 0; i < 16; i++) send(8'(i), i == 15, 0);
    chk("fill_done", {31'b0, done_b}, 32'd1);
    chk("fill_err", {31'b0, err_b}, 32'd0);
    chk("fill_cnt", {29'b0, cnt_b}, 32'd4);
    rom_ce = 1'b1;
    rom_addr = 32'hC;
    #1;
    chk("fill_w3", data_b, 32'h0C0D_0E0F);

    // Overflow: 16 bytes without last
    do_reset();
    for (int i = 0; i < 16; i++) send(8'(i + 16), 1'b0, 0);
    chk("ovf_err", {31'b0, err_b}, 32'd1);
    chk("ovf_done", {31'b0, done_b}, 32'd0);
    chk("ovf_cnt", {29'b0, cnt_b}, 32'd4);
    chk("ovf_cpu_rst", {31'b0, cpu_rst_b}, 32'd1);
    chk("big_still_loading", {31'b0, ready_a}, 32'd1);
    chk("big_cnt", {21'b0, cnt_a}, 32'd4);

    // Async reset between edges after 5 bytes
    do_reset();
    for (int i = 0; i < 5; i++) send(img[i], 1'b0, 0);
    chk("mid_cnt_before", {21'b0, cnt_a}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_cnt", {21'b0, cnt_a}, 32'd0);
    chk("async_ready", {31'b0, ready_a}, 32'd1);
    chk("async_cpu_rst", {31'b0, cpu_rst_a}, 32'd1);
    chk("async_done", {31'b0, done_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send(8'hAA, 1'b0, 0);
    send(8'hBB, 1'b0, 0);
    send(8'hCC, 1'b0, 0);
    send(8'hDD, 1'b1, 0);
    chk("reload_cnt", {21'b0, cnt_a}, 32'd1);
    fetch("reload_w0", 1'b1, 32'h0, 32'hAABB_CCDD);
    fetch("reload_w1_stale", 1'b1, 32'h4, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
- Instruction memory that sits directly upstream of the CPU core. It drives the core's rom_data_i and consumes the core's rom_addr_o and rom_ce_o.
- Contents are loaded at boot through a byte-stream port (UART/JTAG bridge). Four bytes are assembled into each big-endian word and written sequentially from word 0.
- The core is held in reset until the last byte is accepted. After that the block serves combinational instruction fetches.

Parameters:
- ADDR_W, 10, word-address width; capacity is 2^ADDR_W 32-bit words.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- ld_valid_i  input  1  load byte valid.
- ld_byte_i  input  8  load byte.
- ld_last_i  input  1  qualifies the final byte of the image.
- ld_ready_o  output  1  block accepts a load byte this cycle.
- rom_ce_i  input  1  fetch enable from the core.
- rom_addr_i  input  32  fetch byte address from the core.
- rom_data_o  output  32  fetched instruction.
- cpu_rst_o  output  1  reset to the core, active-high.
- ld_done_o  output  1  image loaded; core running.
- ld_err_o  output  1  load protocol error, sticky.
- word_cnt_o  output  ADDR_W+1  number of words written.

Behaviour:
- Reset is asynchronous and active-high. It forces:
  - state LOAD, byte index 0, assembly register 0, word_cnt_o 0;
  - ld_ready_o 1, cpu_rst_o 1, ld_done_o 0, ld_err_o 0, rom_data_o 0.
  - Memory array contents are not cleared.
- All outputs except rom_data_o decode directly from flops; no combinational glitches.
- State machine has three states: LOAD, RUN, ERR.
- LOAD:
  - ld_ready_o=1. A byte is accepted on a rising clk when ld_valid_i & ld_ready_o.
  - Byte order is big-endian: index 0 goes to [31:24], 1 to [23:16], 2 to [15:8], 3 to [7:0].
  - On accepting the index-3 byte, the full word (assembly register plus the current byte) is written to mem[word_cnt] in that same clock. word_cnt then increments and the index returns to 0.
  - Accepted byte with ld_last_i=1 at index 3: the word is written, next state is RUN.
  - Accepted byte with ld_last_i=1 at index 0..2: the partial word is discarded, next state is ERR.
  - Word written into slot 2^ADDR_W-1 with ld_last_i=0: the write still occurs, word_cnt becomes 2^ADDR_W, next state is ERR (overflow).
  - Word written into slot 2^ADDR_W-1 with ld_last_i=1: next state is RUN (exact fill is legal).
  - ld_valid_i=0, or ld_last_i without ld_valid_i: no effect.
- RUN:
  - ld_ready_o=0, cpu_rst_o=0, ld_done_o=1.
  - Load-port inputs are ignored. The state holds until rst.
  - cpu_rst_o falls on the clock edge that enters RUN. The core's first fetch therefore occurs the cycle after.
- ERR:
  - ld_ready_o=0, cpu_rst_o=1, ld_err_o=1, ld_done_o=0.
  - Only rst exits this state.
- Fetch path is combinational with 0-cycle latency. Word index = rom_addr_i[ADDR_W+1:2].
  - rom_addr_i[1:0] is ignored.
  - Bits above ADDR_W+1 are ignored, so the image aliases across the address space.
  - rom_data_o = mem[index] only when rom_ce_i=1 AND state=RUN AND index < word_cnt.
  - Otherwise rom_data_o = 32'h0 (NOP). This covers unwritten or stale words, LOAD, ERR and ce low.
- Memory write port is used only in LOAD, so there is no read/write collision in RUN.
- Reset mid-load: the partial word and count are lost. Reload restarts at word 0. Stale memory is masked by the word_cnt compare.
- word_cnt_o is width ADDR_W+1 so that the full count 2^ADDR_W is representable.

Test Plan:
- Basic load: send 8 bytes 34 01 00 05 3C 02 12 34 (last on byte 8).
  - Required: word_cnt_o=2, ld_done_o=1, cpu_rst_o falls on the accepting edge.
  - Fetch addr 0 gives 32'h34010005; addr 4 gives 32'h3C021234; addr 8 gives 0.
- Gating: after the load above, rom_ce_i=0 at addr 0 gives rom_data_o=0.
  - Addr 32'h0000_1004 (ADDR_W=10) aliases to word 1 and gives 32'h3C021234.
- Backpressure/gaps: insert random ld_valid_i=0 cycles between bytes.
  - Required: identical memory image and count.
  - After RUN, further valid bytes do not change word_cnt_o or contents.
- Early last: ld_last_i on the 6th byte.
  - Required: ld_err_o=1, cpu_rst_o stays 1, word_cnt_o=1, ld_ready_o=0, all fetches return 0.
- Overflow, ADDR_W=2:
  - 16 bytes with last on byte 16 gives RUN with word_cnt_o=4.
  - 16 bytes with no last gives ERR with word_cnt_o=4.
- Async reset mid-load: assert rst between clk edges after 5 bytes.
  - Required: outputs return to their reset values immediately without waiting for a clk edge.
  - Reload of 4 bytes AA BB CC DD with last gives addr 0 = 32'hAABBCCDD and addr 4 = 0.
